// File: rtl/store_narrow_serializer.sv
// store_narrow_serializer
//
// Store-side counterpart of the load-path sign extender. A 32-bit register
// value is narrowed to a byte, halfword or word store, checked for
// representability (sign-extending the narrowed value must rebuild the
// original), and serialized onto a 16-bit memory write bus using valid/ready
// handshakes. A word store takes two beats (low half first); bytes and
// halves take one.
//
// Parameters:
//   STRICT_TRUNC  0: emit truncated data and flag it on trunc_err
//                 1: drop a truncating request (no beats) and pulse trunc_err
//
// Optional feature (macro STORE_NARROW_STATS_EN):
//   trunc_count  16-bit saturating count of truncating transactions
//   beat_count   16-bit wrapping count of completed beat handshakes
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   store request valid
//   in_ready   block can accept a request (high only when idle)
//   in_data    register data to store
//   in_size    0=byte, 1=half, 2=word, 3=reserved
//   in_addr    byte address bits [1:0]
//   out_valid  write beat valid
//   out_ready  memory accepts beat
//   out_data   write data lanes
//   out_be     byte enables, bit0 = low lane
//   out_hi     halfword select within the word
//   out_last   final beat of the transaction
//   trunc_err  transaction value does not fit in the requested size
//   align_err  one-cycle pulse: misaligned or reserved request dropped

module store_narrow_serializer #(
    parameter bit STRICT_TRUNC = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [1:0]  in_size,
    input  logic [1:0]  in_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_be,
    output logic        out_hi,
    output logic        out_last,
    output logic        trunc_err,
    output logic        align_err
`ifdef STORE_NARROW_STATS_EN
    ,
    output logic [15:0] trunc_count,
    output logic [15:0] beat_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t      state_r;
    logic [15:0] data_hi_r;   // upper half kept for the second word beat
    logic        is_word_r;

    logic        accept_s;
    logic        hs_s;
    logic        mis_s;
    logic        trunc_s;
    logic        word_s;
    logic [15:0] beat_data_s;
    logic [1:0]  beat_be_s;
    logic        beat_hi_s;
    logic        beat_last_s;

    // A byte fits when bits [31:8] are copies of its sign bit.
    function automatic logic fits_byte(input logic [31:0] d);
        return d[31:8] == {24{d[7]}};
    endfunction

    // A halfword fits when bits [31:16] are copies of its sign bit.
    function automatic logic fits_half(input logic [31:0] d);
        return d[31:16] == {16{d[15]}};
    endfunction

    // Handshake qualifiers.
    always_comb begin
        accept_s = in_valid && in_ready;
        hs_s     = out_valid && out_ready;
    end

    // Decode the incoming request into error flags and its first beat.
    always_comb begin
        mis_s       = 1'b0;
        trunc_s     = 1'b0;
        word_s      = 1'b0;
        beat_data_s = in_data[15:0];
        beat_be_s   = 2'b11;
        beat_hi_s   = in_addr[1];
        beat_last_s = 1'b1;
        case (in_size)
            2'd0: begin
                trunc_s     = !fits_byte(in_data);
                beat_data_s = {in_data[7:0], in_data[7:0]};
                beat_be_s   = in_addr[0] ? 2'b10 : 2'b01;
            end
            2'd1: begin
                mis_s   = in_addr[0];
                trunc_s = !fits_half(in_data);
            end
            2'd2: begin
                mis_s       = (in_addr != 2'd0);
                word_s      = 1'b1;
                beat_hi_s   = 1'b0;
                beat_last_s = 1'b0;
            end
            default: begin
                mis_s = 1'b1;
            end
        endcase
    end

    // Serializer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= 16'd0;
            out_be    <= 2'b00;
            out_hi    <= 1'b0;
            out_last  <= 1'b0;
            trunc_err <= 1'b0;
            align_err <= 1'b0;
            data_hi_r <= 16'd0;
            is_word_r <= 1'b0;
        end else begin
            align_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    trunc_err <= 1'b0;
                    if (accept_s) begin
                        if (mis_s) begin
                            align_err <= 1'b1;
                        end else if (trunc_s && STRICT_TRUNC) begin
                            trunc_err <= 1'b1;
                        end else begin
                            state_r   <= BEAT0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= beat_data_s;
                            out_be    <= beat_be_s;
                            out_hi    <= beat_hi_s;
                            out_last  <= beat_last_s;
                            trunc_err <= trunc_s;
                            data_hi_r <= in_data[31:16];
                            is_word_r <= word_s;
                        end
                    end
                end
                BEAT0: begin
                    if (hs_s && is_word_r) begin
                        state_r  <= BEAT1;
                        out_data <= data_hi_r;
                        out_hi   <= 1'b1;
                        out_last <= 1'b1;
                    end else if (hs_s) begin
                        state_r   <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        trunc_err <= 1'b0;
                    end
                end
                BEAT1: begin
                    if (hs_s) begin
                        state_r   <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        trunc_err <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    trunc_err <= 1'b0;
                end
            endcase
        end
    end

`ifdef STORE_NARROW_STATS_EN
    // Statistics: truncating requests (emitted or dropped) and completed beats.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trunc_count <= 16'd0;
            beat_count  <= 16'd0;
        end else begin
            if (accept_s && !mis_s && trunc_s && (trunc_count != 16'hFFFF)) begin
                trunc_count <= trunc_count + 16'd1;
            end
            if (hs_s) begin
                beat_count <= beat_count + 16'd1;
            end
        end
    end
`endif

endmodule
